// File: rtl/mem_xfer_pkg.sv
// Shared types and sizing helpers for the mem_xfer_fsm sequencing engine.
package mem_xfer_pkg;

    typedef enum logic [1:0] {
        MODE_COPY   = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_INVERT = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } state_t;

    localparam int PKG_DATA_W     = 32;
    localparam int BYTES_PER_WORD = PKG_DATA_W / 8;

    // Modules carry their own DATA_W parameter, so the stride is derived per instance.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_xfer_agu.sv
// Address generator: holds source/destination bases, word index and length,
// and presents current/next word addresses plus the last-word flag.
module mem_xfer_agu
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  count,
    output logic [ADDR_W-1:0] src_cur,
    output logic [ADDR_W-1:0] dst_cur,
    output logic [ADDR_W-1:0] src_next,
    output logic [ADDR_W-1:0] dst_next,
    output logic              last
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(bytes_per_word(DATA_W));

    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [LEN_W:0]    idx_inc;
    logic [ADDR_W-1:0] cur_off;
    logic [ADDR_W-1:0] next_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            idx_reg <= '0;
        end else if (load) begin
            src_reg <= src_base;
            dst_reg <= dst_base;
            len_reg <= count;
            idx_reg <= '0;
        end else if (step) begin
            idx_reg <= idx_reg + 1'b1;
        end
    end

    // Extra bit keeps the compare correct when len is the maximum count.
    assign idx_inc  = {1'b0, idx_reg} + {{LEN_W{1'b0}}, 1'b1};
    assign last     = (idx_inc == {1'b0, len_reg});

    // Address arithmetic wraps silently modulo 2^ADDR_W.
    assign cur_off  = ADDR_W'(idx_reg) * STRIDE;
    assign next_off = cur_off + STRIDE;
    assign src_cur  = src_reg + cur_off;
    assign dst_cur  = dst_reg + cur_off;
    assign src_next = src_reg + next_off;
    assign dst_next = dst_reg + next_off;

endmodule

// File: rtl/mem_xfer_fsm.sv
// Memory sequencing engine: COPY, FILL or in-place INVERT over a word range.
// Optional MEM_XFER_CHECKSUM_EN builds a running sum of written words.
module mem_xfer_fsm
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] checksum
);

    state_t            state;
    mode_t             mode_reg;
    logic [DATA_W-1:0] pattern_reg;
    logic              accept;
    logic              reserved_mode;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;
    logic [ADDR_W-1:0] src_next;
    logic [ADDR_W-1:0] dst_next;
    logic              last;

    assign accept        = (state == ST_IDLE) && start;
    assign reserved_mode = (mode == 2'd3);

    mem_xfer_agu #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_agu (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state == ST_WR),
        .src_base (src_addr),
        .dst_base (dst_addr),
        .count    (len),
        .src_cur  (src_cur),
        .dst_cur  (dst_cur),
        .src_next (src_next),
        .dst_next (dst_next),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_reg    <= MODE_FILL;
            pattern_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_en       <= 1'b0;
            addr        <= '0;
            data_out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        // Reserved mode behaves as a FILL of zeros.
                        mode_reg    <= reserved_mode ? MODE_FILL : mode_t'(mode);
                        pattern_reg <= reserved_mode ? '0 : pattern;
                        if (len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (mode == MODE_COPY || mode == MODE_INVERT) begin
                            state <= ST_RD;
                            wr_en <= 1'b0;
                            addr  <= src_addr;
                        end else begin
                            state    <= ST_WR;
                            wr_en    <= 1'b1;
                            addr     <= dst_addr;
                            data_out <= reserved_mode ? '0 : pattern;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // data_out doubles as the captured-word register.
                    state <= ST_WR;
                    wr_en <= 1'b1;
                    if (mode_reg == MODE_INVERT) begin
                        addr     <= src_cur;
                        data_out <= ~data_in;
                    end else begin
                        addr     <= dst_cur;
                        data_out <= data_in;
                    end
                end
                ST_WR: begin
                    if (last) begin
                        state <= ST_DONE;
                        wr_en <= 1'b0;
                        done  <= 1'b1;
                    end else if (mode_reg == MODE_FILL) begin
                        addr     <= dst_next;
                        data_out <= pattern_reg;
                    end else begin
                        state <= ST_RD;
                        wr_en <= 1'b0;
                        addr  <= src_next;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_XFER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (accept) begin
            sum_reg <= '0;
        end else if (wr_en) begin
            sum_reg <= sum_reg + data_out;
        end
    end

    assign checksum = sum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Directed bench for mem_xfer_fsm against a 16-byte synchronous single-port memory.
module tb_mem_xfer_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [7:0]  len = '0;
    logic [31:0] pattern = '0;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic [31:0] checksum;

    logic [31:0] mem [4];
    logic [31:0] init_val [4];
    logic        load_mem = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_xfer_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .checksum (checksum)
    );

    always @(posedge clk) begin
        if (load_mem) begin
            for (int k = 0; k < 4; k++) mem[k] <= init_val[k];
        end else if (wr_en && addr < 32'd16) begin
            mem[addr[3:2]] <= data_out;
        end
        data_in <= (addr < 32'd16) ? mem[addr[3:2]] : 32'h0;
    end

    task automatic preload(input logic [31:0] w0, w1, w2, w3);
        init_val[0] = w0; init_val[1] = w1; init_val[2] = w2; init_val[3] = w3;
        load_mem = 1'b1;
        @(posedge clk); #1;
        load_mem = 1'b0;
    endtask

    // Issues one start, then counts cycles (accept edge = cycle 1 boundary) until done.
    task automatic run_xfer(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                            input logic [7:0] l, input logic [31:0] p,
                            output int cyc, output bit saw_wr);
        mode = m; src_addr = s; dst_addr = d; len = l; pattern = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        saw_wr = wr_en;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            saw_wr |= wr_en;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", wr_en); else n_pass++;
        n_checks++; if (addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", addr); else n_pass++;
        n_checks++; if (data_out !== 32'h0) $display("FAIL reset_data_out: got %h expected 0", data_out); else n_pass++;
        n_checks++; if (checksum !== 32'h0) $display("FAIL reset_checksum: got %h expected 0", checksum); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset: outputs idle");
    endtask

    task automatic test_fill();
        int cyc;
        bit saw;
        logic [31:0] exp_sum;
        preload(32'h0, 32'h0, 32'h0, 32'h0);
        run_xfer(2'd1, 32'h0, 32'h0, 8'd4, 32'hDEADBEEF, cyc, saw);
        $display("fill: dst=0 len=4 pattern=deadbeef done_cycle=%0d", cyc);
        n_checks++; if (cyc !== 5) $display("FAIL fill_latency: got %0d expected 5", cyc); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem[k] !== 32'hDEADBEEF) $display("FAIL fill_word%0d: got %h expected deadbeef", k, mem[k]);
            else n_pass++;
        end
`ifdef MEM_XFER_CHECKSUM_EN
        exp_sum = 32'h7AB6FBBC;
`else
        exp_sum = 32'h0;
`endif
        n_checks++; if (checksum !== exp_sum) $display("FAIL fill_checksum: got %h expected %h", checksum, exp_sum); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL fill_busy_after: got %b expected 0", busy); else n_pass++;
        run_xfer(2'd3, 32'h0, 32'h4, 8'd1, 32'hFFFFFFFF, cyc, saw);
        $display("reserved mode: dst=4 len=1 done_cycle=%0d", cyc);
        n_checks++; if (mem[1] !== 32'h0) $display("FAIL reserved_zero_fill: got %h expected 0", mem[1]); else n_pass++;
        n_checks++; if (cyc !== 2) $display("FAIL reserved_latency: got %0d expected 2", cyc); else n_pass++;
    endtask

    task automatic test_copy();
        int cyc;
        bit saw;
        preload(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        run_xfer(2'd0, 32'h0, 32'h8, 8'd2, 32'h0, cyc, saw);
        $display("copy: src=0 dst=8 len=2 done_cycle=%0d", cyc);
        n_checks++; if (cyc !== 7) $display("FAIL copy_latency: got %0d expected 7", cyc); else n_pass++;
        n_checks++; if (mem[0] !== 32'h11111111) $display("FAIL copy_word0: got %h expected 11111111", mem[0]); else n_pass++;
        n_checks++; if (mem[1] !== 32'h22222222) $display("FAIL copy_word1: got %h expected 22222222", mem[1]); else n_pass++;
        n_checks++; if (mem[2] !== 32'h11111111) $display("FAIL copy_word2: got %h expected 11111111", mem[2]); else n_pass++;
        n_checks++; if (mem[3] !== 32'h22222222) $display("FAIL copy_word3: got %h expected 22222222", mem[3]); else n_pass++;
    endtask

    task automatic test_invert();
        int cyc;
        bit saw;
        preload(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678, 32'h9ABCDEF0);
        run_xfer(2'd2, 32'h4, 32'hC, 8'd1, 32'h0, cyc, saw);
        $display("invert: src=4 len=1 done_cycle=%0d", cyc);
        n_checks++; if (cyc !== 4) $display("FAIL invert_latency: got %0d expected 4", cyc); else n_pass++;
        n_checks++; if (mem[1] !== 32'hF0F0F0F0) $display("FAIL invert_word1: got %h expected f0f0f0f0", mem[1]); else n_pass++;
        n_checks++; if (mem[0] !== 32'hA5A5A5A5) $display("FAIL invert_word0: got %h expected a5a5a5a5", mem[0]); else n_pass++;
        n_checks++; if (mem[2] !== 32'h12345678) $display("FAIL invert_word2: got %h expected 12345678", mem[2]); else n_pass++;
        n_checks++; if (mem[3] !== 32'h9ABCDEF0) $display("FAIL invert_word3: got %h expected 9abcdef0", mem[3]); else n_pass++;
    endtask

    task automatic test_len_zero();
        int cyc;
        bit saw;
        preload(32'h1, 32'h2, 32'h3, 32'h4);
        run_xfer(2'd0, 32'h0, 32'h8, 8'd0, 32'h0, cyc, saw);
        $display("len0: copy done_cycle=%0d wr_seen=%0b", cyc, saw);
        n_checks++; if (cyc !== 1) $display("FAIL len0_latency: got %0d expected 1", cyc); else n_pass++;
        n_checks++; if (saw !== 1'b0) $display("FAIL len0_no_write: got %b expected 0", saw); else n_pass++;
        n_checks++; if (mem[2] !== 32'h3) $display("FAIL len0_mem: got %h expected 3", mem[2]); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int cyc;
        preload(32'h0, 32'h0, 32'h0, 32'h0);
        mode = 2'd1; src_addr = 32'h0; dst_addr = 32'h0; len = 8'd4; pattern = 32'hCAFEF00D;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        // Hold a conflicting command while the fill runs.
        mode = 2'd0; src_addr = 32'h4; dst_addr = 32'h8; len = 8'd1; pattern = 32'h0BADBAD0;
        @(posedge clk); #1; cyc++;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        $display("busy_start: fill len=4 done_cycle=%0d", cyc);
        n_checks++; if (cyc !== 5) $display("FAIL busy_latency: got %0d expected 5", cyc); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem[k] !== 32'hCAFEF00D) $display("FAIL busy_word%0d: got %h expected cafef00d", k, mem[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit saw;
        preload(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
        mode = 2'd1; src_addr = 32'h0; dst_addr = 32'h0; len = 8'd4; pattern = 32'h12345678;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (wr_en !== 1'b0) $display("FAIL midrst_wr_en: got %b expected 0", wr_en); else n_pass++;
        n_checks++; if (addr !== 32'h0) $display("FAIL midrst_addr: got %h expected 0", addr); else n_pass++;
        n_checks++; if (data_out !== 32'h0) $display("FAIL midrst_data_out: got %h expected 0", data_out); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (checksum !== 32'h0) $display("FAIL midrst_checksum: got %h expected 0", checksum); else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("mid_reset: fill aborted during second word");
        n_checks++; if (mem[0] !== 32'h12345678) $display("FAIL midrst_word0: got %h expected 12345678", mem[0]); else n_pass++;
        n_checks++; if (mem[2] !== 32'h77777777) $display("FAIL midrst_word2: got %h expected 77777777", mem[2]); else n_pass++;
        n_checks++; if (mem[3] !== 32'h88888888) $display("FAIL midrst_word3: got %h expected 88888888", mem[3]); else n_pass++;
        run_xfer(2'd1, 32'h0, 32'hC, 8'd1, 32'h0BEEF000, cyc, saw);
        $display("post_reset: fill dst=c len=1 done_cycle=%0d", cyc);
        n_checks++; if (cyc !== 2) $display("FAIL postrst_latency: got %0d expected 2", cyc); else n_pass++;
        n_checks++; if (mem[3] !== 32'h0BEEF000) $display("FAIL postrst_word3: got %h expected 0beef000", mem[3]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_invert();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_xfer_fsm.md
# mem_xfer_fsm

Parametrised memory-sequencing engine that replaces the fixed single-purpose memory FSM. On a start pulse it performs one of three word-level operations over a programmable address range: copy, fill or in-place invert, with done signalling. It sits between a control source (testbench or host FSM) and the single-port `mem` model, driving `wr_en`/`addr`/`data_out` and consuming `data_in`.

## Interface
- `DATA_W`, default 32: memory word width in bits; multiple of 8.
- `ADDR_W`, default 32: byte-address width.
- `LEN_W`, default 8: width of the word-count field; maximum transfer is 2^LEN_W−1 words.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `mode`  in  2  0 = COPY, 1 = FILL, 2 = INVERT, 3 = reserved (treated as FILL with zero pattern).
- `src_addr`  in  ADDR_W  byte address of the first source word (COPY, INVERT).
- `dst_addr`  in  ADDR_W  byte address of the first destination word (COPY, FILL).
- `len`  in  LEN_W  number of words.
- `pattern`  in  DATA_W  fill value.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `wr_en`  out  1  memory write enable.
- `addr`  out  ADDR_W  memory byte address.
- `data_out`  out  DATA_W  write data to memory.
- `data_in`  in  DATA_W  read data from memory, valid one cycle after `addr` is presented.
- `checksum`  out  DATA_W  running sum of written words (see Configuration).

## Operation
- States: IDLE, RD, WAIT, WR, DONE.
- IDLE: on `start`=1, latch `mode`, `src_addr`, `dst_addr`, `len` and `pattern`, clear the word index and checksum.
  - `len`=0: go to DONE; no memory access.
  - FILL: go to WR.
  - COPY or INVERT: go to RD.
- RD: `addr` = src + i·(DATA_W/8), `wr_en`=0. Then WAIT.
- WAIT: capture `data_in` into the data register. Then WR.
- WR: `wr_en`=1.
  - COPY: `addr` = dst + offset, `data_out` = captured word.
  - INVERT: `addr` = src + offset, `data_out` = ~captured word.
  - FILL: `addr` = dst + offset, `data_out` = `pattern`.
  - Increment i. If i reaches `len`, go to DONE. Otherwise go to RD (COPY, INVERT) or stay in WR (FILL).
- DONE: `done`=1, then IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent. Overlapping COPY ranges are processed in ascending order, with no overlap correction.
- `start` is ignored outside IDLE. Latched parameters do not follow input changes during a transfer.
- Reset mid-transfer aborts immediately: no further writes, and the state returns to IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_en`=0, `addr`=0, `data_out`=0, `checksum`=0.
- `addr`, `wr_en` and `data_out` are registered outputs, updated on the edge that enters the state.
- Start-accept edge to `done` high:
  - COPY / INVERT: 3·len+1 cycles.
  - FILL: len+1 cycles.
  - len=0: 1 cycle.
- `busy` rises on the edge after `start` is accepted and falls on the edge after DONE.
- A new `start` can be accepted on the first cycle back in IDLE.

## Configuration
- `MEM_XFER_CHECKSUM_EN` defined: `checksum` accumulates the DATA_W-bit sum, modulo 2^DATA_W, of every word written. It is cleared on start accept, holds its value after DONE, and is cleared on reset.
- `MEM_XFER_CHECKSUM_EN` undefined: no accumulator is built and `checksum` is constant 0.

## Structure
- `mem_xfer_pkg` holds:
  - the mode enum (COPY, FILL, INVERT);
  - the state enum;
  - the localparam `BYTES_PER_WORD = DATA_W/8`.
- One sub-module, `mem_xfer_agu`: the address generator. It holds the base address and word index and produces the offset address and the last-word flag.

## Test plan
- FILL, dst=0x0, len=4, pattern=0xDEADBEEF, 16-byte mem → all four words read 0xDEADBEEF; `done` exactly 5 cycles after accept; checksum 0x7AB6FBBC (macro on).
- COPY, src=0x0, dst=0x8, len=2, mem words {0x11111111, 0x22222222, …} → words 2 and 3 become 0x11111111 and 0x22222222; `done` at cycle 7.
- INVERT, src=0x4, len=1, word 1 = 0x0F0F0F0F → word 1 becomes 0xF0F0F0F0; other words unchanged.
- len=0, any mode → `done` one cycle after accept; `wr_en` never asserts.
- Assert `start` again while busy, with different parameters → ignored; the original transfer completes unchanged.
- Assert `rst` during the WR of word 2 of a 4-word FILL → all outputs 0 asynchronously; words 3 and 4 retain their old contents; a new start is accepted afterwards.
